// File: rtl/nv_nvdla_sdp_erdma_pkg.sv
// Shared ERDMA definitions: atom geometry, ingress FSM states and context-entry layout.
package nv_nvdla_sdp_erdma_pkg;

    localparam int AW          = 64;
    localparam int ATOM_B      = 32;
    localparam int ATOM_SHIFT  = $clog2(ATOM_B);
    localparam int ATOM_AW     = AW - ATOM_SHIFT;
    localparam int MAX_BURST   = 8;
    localparam int SIZE_W      = $clog2(MAX_BURST);
    localparam int CNT_W       = 13;
    localparam int REQ_SIZE_W  = 15;
    localparam int CQ_PD_W     = 16;

    localparam int CQ_SIZE_LSB  = 0;
    localparam int CQ_SIZE_MSB  = 2;
    localparam int CQ_LINE_END  = 3;
    localparam int CQ_SURF_END  = 4;
    localparam int CQ_LAYER_END = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } ig_state_e;

    function automatic logic [CQ_PD_W-1:0] cq_pack(
        input logic [SIZE_W-1:0] size_m1,
        input logic              line_end,
        input logic              surf_end,
        input logic              layer_end
    );
        logic [CQ_PD_W-1:0] pd;
        pd = {CQ_PD_W{1'b0}};
        pd[CQ_SIZE_MSB:CQ_SIZE_LSB] = size_m1;
        pd[CQ_LINE_END]             = line_end;
        pd[CQ_SURF_END]             = surf_end;
        pd[CQ_LAYER_END]            = layer_end;
        return pd;
    endfunction

endpackage

// File: rtl/nv_nvdla_sdp_erdma_ig_req_gen_addr_walk.sv
// Surface walker: latches the register set, tracks x/y/s and the atom address of the
// current burst, and advances one burst per accepted request.
module nv_nvdla_sdp_erdma_ig_addr_walk
    import nv_nvdla_sdp_erdma_pkg::*;
(
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rst,
    input  logic                walk_load,
    input  logic                walk_adv,
    input  logic [AW-1:0]       cfg_base_addr,
    input  logic [ATOM_AW-1:0]  cfg_line_stride,
    input  logic [ATOM_AW-1:0]  cfg_surf_stride,
    input  logic [CNT_W-1:0]    cfg_width_m1,
    input  logic [CNT_W-1:0]    cfg_height_m1,
    input  logic [CNT_W-1:0]    cfg_surf_m1,
    output logic [AW-1:0]       walk_addr,
    output logic [SIZE_W-1:0]   walk_size_m1,
    output logic                walk_line_end,
    output logic                walk_surf_end,
    output logic                walk_layer_end
);

    logic [CNT_W-1:0]   width_m1_r;
    logic [CNT_W-1:0]   height_m1_r;
    logic [CNT_W-1:0]   surf_m1_r;
    logic [ATOM_AW-1:0] line_stride_r;
    logic [ATOM_AW-1:0] surf_stride_r;
    logic [CNT_W-1:0]   x_r;
    logic [CNT_W-1:0]   y_r;
    logic [CNT_W-1:0]   s_r;
    logic [ATOM_AW-1:0] line_addr_r;
    logic [ATOM_AW-1:0] surf_addr_r;
    logic [ATOM_AW-1:0] cur_atom_r;

    logic [CNT_W-1:0]   rem_s;
    logic [CNT_W-1:0]   step_s;
    logic [ATOM_AW-1:0] next_line_s;
    logic [ATOM_AW-1:0] next_surf_s;
    logic               base_lsb_unused_s;

    // The byte offset inside an atom is dropped: requests are always atom aligned.
    assign base_lsb_unused_s = ^cfg_base_addr[ATOM_SHIFT-1:0];

    // Burst sizing and end-of-line/surface/layer detection for the current position.
    always_comb begin
        rem_s = width_m1_r - x_r;
        if (rem_s > CNT_W'(MAX_BURST - 1)) begin
            walk_size_m1  = SIZE_W'(MAX_BURST - 1);
            walk_line_end = 1'b0;
        end else begin
            walk_size_m1  = rem_s[SIZE_W-1:0];
            walk_line_end = 1'b1;
        end
        walk_surf_end  = walk_line_end && (y_r == height_m1_r);
        walk_layer_end = walk_surf_end && (s_r == surf_m1_r);
        step_s         = {{(CNT_W-SIZE_W){1'b0}}, walk_size_m1} + {{(CNT_W-1){1'b0}}, 1'b1};
        next_line_s    = line_addr_r + line_stride_r;
        next_surf_s    = surf_addr_r + surf_stride_r;
    end

    assign walk_addr = {cur_atom_r, {ATOM_SHIFT{1'b0}}};

    // Config latch on load; position and address registers step on each accepted burst.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            width_m1_r    <= {CNT_W{1'b0}};
            height_m1_r   <= {CNT_W{1'b0}};
            surf_m1_r     <= {CNT_W{1'b0}};
            line_stride_r <= {ATOM_AW{1'b0}};
            surf_stride_r <= {ATOM_AW{1'b0}};
            x_r           <= {CNT_W{1'b0}};
            y_r           <= {CNT_W{1'b0}};
            s_r           <= {CNT_W{1'b0}};
            line_addr_r   <= {ATOM_AW{1'b0}};
            surf_addr_r   <= {ATOM_AW{1'b0}};
            cur_atom_r    <= {ATOM_AW{1'b0}};
        end else if (walk_load) begin
            width_m1_r    <= cfg_width_m1;
            height_m1_r   <= cfg_height_m1;
            surf_m1_r     <= cfg_surf_m1;
            line_stride_r <= cfg_line_stride;
            surf_stride_r <= cfg_surf_stride;
            x_r           <= {CNT_W{1'b0}};
            y_r           <= {CNT_W{1'b0}};
            s_r           <= {CNT_W{1'b0}};
            line_addr_r   <= cfg_base_addr[AW-1:ATOM_SHIFT];
            surf_addr_r   <= cfg_base_addr[AW-1:ATOM_SHIFT];
            cur_atom_r    <= cfg_base_addr[AW-1:ATOM_SHIFT];
        end else if (walk_adv) begin
            if (!walk_line_end) begin
                x_r        <= x_r + step_s;
                cur_atom_r <= cur_atom_r + {{(ATOM_AW-CNT_W){1'b0}}, step_s};
            end else if (!walk_surf_end) begin
                x_r         <= {CNT_W{1'b0}};
                y_r         <= y_r + {{(CNT_W-1){1'b0}}, 1'b1};
                line_addr_r <= next_line_s;
                cur_atom_r  <= next_line_s;
            end else begin
                x_r         <= {CNT_W{1'b0}};
                y_r         <= {CNT_W{1'b0}};
                s_r         <= s_r + {{(CNT_W-1){1'b0}}, 1'b1};
                surf_addr_r <= next_surf_s;
                line_addr_r <= next_surf_s;
                cur_atom_r  <= next_surf_s;
            end
        end
    end

endmodule

// File: rtl/nv_nvdla_sdp_erdma_ig_req_gen.sv
// ERDMA ingress request generator: FSM and DMA/context-queue handshake around the
// surface walker. One context entry is pushed for every accepted DMA read.
module nv_nvdla_sdp_erdma_ig_req_gen
    import nv_nvdla_sdp_erdma_pkg::*;
(
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rst,
    input  logic                   op_load,
    input  logic [AW-1:0]          cfg_base_addr,
    input  logic [ATOM_AW-1:0]     cfg_line_stride,
    input  logic [ATOM_AW-1:0]     cfg_surf_stride,
    input  logic [CNT_W-1:0]       cfg_width_m1,
    input  logic [CNT_W-1:0]       cfg_height_m1,
    input  logic [CNT_W-1:0]       cfg_surf_m1,
    output logic                   dma_rd_req_pvld,
    input  logic                   dma_rd_req_prdy,
    output logic [AW-1:0]          dma_rd_req_addr,
    output logic [REQ_SIZE_W-1:0]  dma_rd_req_size,
    output logic                   ig2cq_pvld,
    input  logic                   ig2cq_prdy,
    output logic [CQ_PD_W-1:0]     ig2cq_pd,
    output logic                   op_busy,
    output logic                   op_done
);

    ig_state_e           state_r;
    logic                load_s;
    logic                acc_s;
    logic [AW-1:0]       walk_addr_s;
    logic [SIZE_W-1:0]   walk_size_m1_s;
    logic                walk_line_end_s;
    logic                walk_surf_end_s;
    logic                walk_layer_end_s;

    // Valid is gated by the queue's ready so a DMA read never issues without a context slot.
    always_comb begin
        load_s          = op_load && (state_r == IDLE);
        dma_rd_req_pvld = (state_r == REQ) && ig2cq_prdy;
        acc_s           = dma_rd_req_pvld && dma_rd_req_prdy;
        ig2cq_pvld      = acc_s;
    end

    // Payload comes straight from walker registers, so it holds while a request is stalled.
    always_comb begin
        if (state_r == REQ) begin
            dma_rd_req_addr = walk_addr_s;
            dma_rd_req_size = {{(REQ_SIZE_W-SIZE_W){1'b0}}, walk_size_m1_s};
            ig2cq_pd        = cq_pack(walk_size_m1_s, walk_line_end_s,
                                      walk_surf_end_s, walk_layer_end_s);
        end else begin
            dma_rd_req_addr = {AW{1'b0}};
            dma_rd_req_size = {REQ_SIZE_W{1'b0}};
            ig2cq_pd        = {CQ_PD_W{1'b0}};
        end
    end

    // Operation FSM with registered busy/done status.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_r <= IDLE;
            op_busy <= 1'b0;
            op_done <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    op_done <= 1'b0;
                    if (op_load) begin
                        state_r <= REQ;
                        op_busy <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        op_busy <= 1'b0;
                    end
                end
                REQ: begin
                    if (acc_s && walk_layer_end_s) begin
                        state_r <= DONE;
                        op_busy <= 1'b0;
                        op_done <= 1'b1;
                    end else begin
                        state_r <= REQ;
                        op_busy <= 1'b1;
                        op_done <= 1'b0;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    op_busy <= 1'b0;
                    op_done <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    op_busy <= 1'b0;
                    op_done <= 1'b0;
                end
            endcase
        end
    end

    nv_nvdla_sdp_erdma_ig_addr_walk u_addr_walk (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rst  (nvdla_core_rst),
        .walk_load       (load_s),
        .walk_adv        (acc_s),
        .cfg_base_addr   (cfg_base_addr),
        .cfg_line_stride (cfg_line_stride),
        .cfg_surf_stride (cfg_surf_stride),
        .cfg_width_m1    (cfg_width_m1),
        .cfg_height_m1   (cfg_height_m1),
        .cfg_surf_m1     (cfg_surf_m1),
        .walk_addr       (walk_addr_s),
        .walk_size_m1    (walk_size_m1_s),
        .walk_line_end   (walk_line_end_s),
        .walk_surf_end   (walk_surf_end_s),
        .walk_layer_end  (walk_layer_end_s)
    );

endmodule

// File: tb/tb_nv_nvdla_sdp_erdma_ig_req_gen.sv
// Self-checking bench for the ERDMA ingress request generator: vector table, golden
// sequences, stall/reset corner cases and randomized ops against a nested-loop model.
`timescale 1ns/1ps
module tb_nv_nvdla_sdp_erdma_ig_req_gen;

    logic          nvdla_core_clk = 1'b0;
    logic          nvdla_core_rst;
    logic          op_load;
    logic [63:0]   cfg_base_addr;
    logic [58:0]   cfg_line_stride;
    logic [58:0]   cfg_surf_stride;
    logic [12:0]   cfg_width_m1;
    logic [12:0]   cfg_height_m1;
    logic [12:0]   cfg_surf_m1;
    logic          dma_rd_req_pvld;
    logic          dma_rd_req_prdy;
    logic [63:0]   dma_rd_req_addr;
    logic [14:0]   dma_rd_req_size;
    logic          ig2cq_pvld;
    logic          ig2cq_prdy;
    logic [15:0]   ig2cq_pd;
    logic          op_busy;
    logic          op_done;

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    nv_nvdla_sdp_erdma_ig_req_gen dut (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rst  (nvdla_core_rst),
        .op_load         (op_load),
        .cfg_base_addr   (cfg_base_addr),
        .cfg_line_stride (cfg_line_stride),
        .cfg_surf_stride (cfg_surf_stride),
        .cfg_width_m1    (cfg_width_m1),
        .cfg_height_m1   (cfg_height_m1),
        .cfg_surf_m1     (cfg_surf_m1),
        .dma_rd_req_pvld (dma_rd_req_pvld),
        .dma_rd_req_prdy (dma_rd_req_prdy),
        .dma_rd_req_addr (dma_rd_req_addr),
        .dma_rd_req_size (dma_rd_req_size),
        .ig2cq_pvld      (ig2cq_pvld),
        .ig2cq_prdy      (ig2cq_prdy),
        .ig2cq_pd        (ig2cq_pd),
        .op_busy         (op_busy),
        .op_done         (op_done)
    );

    typedef struct {
        logic [63:0] base;
        logic [58:0] ls;
        logic [58:0] ss;
        logic [12:0] w_m1;
        logic [12:0] h_m1;
        logic [12:0] s_m1;
    } cfg_t;

    typedef struct {
        logic [63:0] addr;
        logic [14:0] size;
        logic [15:0] pd;
    } req_t;

    typedef struct {
        cfg_t        cfg;
        int          n_req;
        logic [63:0] first_addr;
        logic [63:0] last_addr;
        logic [15:0] last_pd;
    } vec_t;

    req_t exp_q[$];
    req_t obs_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: every request of the op, enumerated surface by surface, line by line.
    function automatic void build_model(input cfg_t c);
        exp_q.delete();
        for (int s = 0; s <= int'(c.s_m1); s++) begin
            for (int y = 0; y <= int'(c.h_m1); y++) begin
                for (int x = 0; x <= int'(c.w_m1); x += 8) begin
                    int          left;
                    bit          le, se, ye;
                    logic [58:0] atom;
                    req_t        r;
                    left   = int'(c.w_m1) - x;
                    le     = (left <= 7);
                    se     = le && (y == int'(c.h_m1));
                    ye     = se && (s == int'(c.s_m1));
                    atom   = c.base[63:5] + 59'(s) * c.ss + 59'(y) * c.ls + 59'(x);
                    r.addr = {atom, 5'b00000};
                    r.size = 15'(le ? left : 7);
                    r.pd   = 16'(r.size) | (le ? 16'h0008 : 16'h0000)
                           | (se ? 16'h0010 : 16'h0000) | (ye ? 16'h0020 : 16'h0000);
                    exp_q.push_back(r);
                end
            end
        end
    endfunction

    task automatic apply_cfg(input cfg_t c);
        cfg_base_addr   = c.base;
        cfg_line_stride = c.ls;
        cfg_surf_stride = c.ss;
        cfg_width_m1    = c.w_m1;
        cfg_height_m1   = c.h_m1;
        cfg_surf_m1     = c.s_m1;
    endtask

    task automatic check_quiet(input string name);
        check({name, " pvld"},    64'(dma_rd_req_pvld), 64'd0);
        check({name, " addr"},    dma_rd_req_addr,      64'd0);
        check({name, " size"},    64'(dma_rd_req_size), 64'd0);
        check({name, " cq_pvld"}, 64'(ig2cq_pvld),      64'd0);
        check({name, " pd"},      64'(ig2cq_pd),        64'd0);
        check({name, " busy"},    64'(op_busy),         64'd0);
        check({name, " done"},    64'(op_done),         64'd0);
    endtask

    // mode 0 both ready, 1 random DMA ready, 2 queue stall cycles 3..7,
    // 3 both random, 4 like 0 plus a stray op_load with junk config while busy.
    task automatic run_op(input cfg_t c, input int mode, input string name);
        int   cyc, done_cnt, first_acc, last_acc, done_cyc, acc_cnt, push_cnt;
        bit   done, prev_hold;
        req_t cur, prev;
        build_model(c);
        obs_q.delete();
        done_cnt = 0; first_acc = -1; last_acc = -1; done_cyc = -1;
        acc_cnt = 0; push_cnt = 0; prev_hold = 1'b0;
        prev = '{64'd0, 15'd0, 16'd0};
        @(negedge nvdla_core_clk);
        apply_cfg(c);
        op_load = 1'b1; dma_rd_req_prdy = 1'b1; ig2cq_prdy = 1'b1;
        #1;
        check({name, " idle_pvld"}, 64'(dma_rd_req_pvld), 64'd0);
        @(negedge nvdla_core_clk);
        op_load = 1'b0;
        cyc = 1; done = 1'b0;
        while (!done && cyc < 3000) begin
            case (mode)
                1:       begin dma_rd_req_prdy = 1'($urandom_range(0, 1)); ig2cq_prdy = 1'b1; end
                2:       begin dma_rd_req_prdy = 1'b1; ig2cq_prdy = !(cyc >= 3 && cyc <= 7); end
                3:       begin dma_rd_req_prdy = 1'($urandom_range(0, 1));
                               ig2cq_prdy = ($urandom_range(0, 3) != 0); end
                default: begin dma_rd_req_prdy = 1'b1; ig2cq_prdy = 1'b1; end
            endcase
            if (mode == 4 && cyc == 2) begin
                op_load = 1'b1;
                cfg_base_addr = 64'hDEAD_BEEF_0000_0000;
                cfg_width_m1 = 13'd2; cfg_height_m1 = 13'd5; cfg_surf_m1 = 13'd5;
            end else begin
                op_load = 1'b0;
            end
            #1;
            cur = '{dma_rd_req_addr, dma_rd_req_size, ig2cq_pd};
            if (prev_hold && op_busy) begin
                check({name, " hold_addr"}, cur.addr, prev.addr);
                check({name, " hold_size"}, 64'(cur.size), 64'(prev.size));
                check({name, " hold_pd"},   64'(cur.pd), 64'(prev.pd));
            end
            if (!ig2cq_prdy)
                check({name, " stall_pvld"}, 64'(dma_rd_req_pvld), 64'd0);
            if (cyc == 1 && ig2cq_prdy)
                check({name, " latency"}, 64'(dma_rd_req_pvld), 64'd1);
            check({name, " push_eq_acc"}, 64'(ig2cq_pvld), 64'(dma_rd_req_pvld && dma_rd_req_prdy));
            if (dma_rd_req_pvld && dma_rd_req_prdy) begin
                acc_cnt++;
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
            if (ig2cq_pvld) begin
                push_cnt++;
                obs_q.push_back(cur);
            end
            if (op_done) begin
                done_cnt++; done_cyc = cyc; done = 1'b1;
            end
            prev_hold = op_busy && !(dma_rd_req_pvld && dma_rd_req_prdy);
            prev = cur;
            @(negedge nvdla_core_clk);
            cyc++;
        end
        op_load = 1'b0;
        if (!done) check({name, " timeout"}, 64'd0, 64'd1);
        check({name, " done_after_last"}, 64'(done_cyc), 64'(last_acc + 1));
        dma_rd_req_prdy = 1'b1; ig2cq_prdy = 1'b1;
        for (int t = 0; t < 3; t++) begin
            #1;
            if (op_done) done_cnt++;
            check({name, " tail_pvld"}, 64'(dma_rd_req_pvld), 64'd0);
            @(negedge nvdla_core_clk);
        end
        check({name, " done_cnt"}, 64'(done_cnt), 64'd1);
        check({name, " push_cnt"}, 64'(push_cnt), 64'(acc_cnt));
        check({name, " n_req"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s req%0d addr", name, i), obs_q[i].addr, exp_q[i].addr);
            check($sformatf("%s req%0d size", name, i), 64'(obs_q[i].size), 64'(exp_q[i].size));
            check($sformatf("%s req%0d pd", name, i),   64'(obs_q[i].pd), 64'(exp_q[i].pd));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[7];
        cfg_t        c1, c2, c3, cr;
        logic [63:0] g1_addr[3];
        logic [15:0] g1_pd[3];
        logic [63:0] g2_addr[4];
        logic [15:0] g2_pd[4];

        c1 = '{64'h1000, 59'd0, 59'd0, 13'd19, 13'd0, 13'd0};
        c2 = '{64'h0, 59'h10, 59'h40, 13'd7, 13'd1, 13'd1};
        c3 = '{64'h2000, 59'd0, 59'd0, 13'd63, 13'd0, 13'd0};
        vecs[0] = '{c1, 3, 64'h1000, 64'h1200, 16'h003B};
        vecs[1] = '{c2, 4, 64'h0, 64'hA00, 16'h003F};
        vecs[2] = '{'{64'h40, 59'd0, 59'd0, 13'd0, 13'd0, 13'd0}, 1, 64'h40, 64'h40, 16'h0038};
        vecs[3] = '{'{64'h0, 59'd0, 59'd0, 13'd15, 13'd0, 13'd0}, 2, 64'h0, 64'h100, 16'h003F};
        vecs[4] = '{'{64'h20, 59'd3, 59'd0, 13'd0, 13'd2, 13'd0}, 3, 64'h20, 64'hE0, 16'h0038};
        vecs[5] = '{'{64'h101F, 59'd0, 59'd0, 13'd0, 13'd0, 13'd0}, 1, 64'h1000, 64'h1000, 16'h0038};
        vecs[6] = '{'{64'hFFFF_FFFF_FFFF_FFE0, 59'd0, 59'd0, 13'd8, 13'd0, 13'd0},
                    2, 64'hFFFF_FFFF_FFFF_FFE0, 64'hE0, 16'h0038};
        g1_addr = '{64'h1000, 64'h1100, 64'h1200};
        g1_pd   = '{16'h0007, 16'h0007, 16'h003B};
        g2_addr = '{64'h000, 64'h200, 64'h800, 64'hA00};
        g2_pd   = '{16'h000F, 16'h001F, 16'h000F, 16'h003F};

        nvdla_core_rst = 1'b1; op_load = 1'b0;
        dma_rd_req_prdy = 1'b0; ig2cq_prdy = 1'b0;
        apply_cfg(c1);
        repeat (2) @(negedge nvdla_core_clk);
        #1;
        check_quiet("reset");
        @(negedge nvdla_core_clk);
        nvdla_core_rst = 1'b0;
        ig2cq_prdy = 1'b1; dma_rd_req_prdy = 1'b1;
        #1;
        check_quiet("idle");

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].cfg, 0, $sformatf("vec%0d", i));
            check($sformatf("vec%0d count", i), 64'(obs_q.size()), 64'(vecs[i].n_req));
            if (obs_q.size() > 0) begin
                check($sformatf("vec%0d first", i), obs_q[0].addr, vecs[i].first_addr);
                check($sformatf("vec%0d last", i), obs_q[obs_q.size()-1].addr, vecs[i].last_addr);
                check($sformatf("vec%0d last_pd", i), 64'(obs_q[obs_q.size()-1].pd), 64'(vecs[i].last_pd));
            end
        end

        run_op(c1, 1, "golden1");
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            check($sformatf("golden1 addr%0d", i), obs_q[i].addr, g1_addr[i]);
            check($sformatf("golden1 pd%0d", i), 64'(obs_q[i].pd), 64'(g1_pd[i]));
        end
        run_op(c2, 1, "golden2");
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            check($sformatf("golden2 addr%0d", i), obs_q[i].addr, g2_addr[i]);
            check($sformatf("golden2 pd%0d", i), 64'(obs_q[i].pd), 64'(g2_pd[i]));
        end

        run_op(c3, 2, "cq_stall");
        run_op(c1, 4, "load_busy");

        // Abort case 1 after two accepts, then rerun it from scratch.
        @(negedge nvdla_core_clk);
        apply_cfg(c1);
        op_load = 1'b1; dma_rd_req_prdy = 1'b1; ig2cq_prdy = 1'b1;
        @(negedge nvdla_core_clk);
        op_load = 1'b0;
        #1;
        check("abort acc1 addr", dma_rd_req_addr, 64'h1000);
        @(negedge nvdla_core_clk);
        #1;
        check("abort acc2 addr", dma_rd_req_addr, 64'h1100);
        @(negedge nvdla_core_clk);
        nvdla_core_rst = 1'b1;
        #1;
        check_quiet("abort rst");
        for (int t = 0; t < 2; t++) begin
            @(negedge nvdla_core_clk);
            #1;
            check_quiet("abort rst hold");
        end
        @(negedge nvdla_core_clk);
        nvdla_core_rst = 1'b0;
        for (int t = 0; t < 3; t++) begin
            #1;
            check("abort no_done", 64'(op_done), 64'd0);
            check("abort idle", 64'(op_busy), 64'd0);
            @(negedge nvdla_core_clk);
        end
        run_op(c1, 0, "rerun");

        for (int k = 0; k < 20; k++) begin
            cr.base = {32'($urandom), 32'($urandom)};
            cr.ls   = 59'($urandom_range(0, 255));
            cr.ss   = 59'($urandom_range(0, 4095));
            cr.w_m1 = 13'($urandom_range(0, 20));
            cr.h_m1 = 13'($urandom_range(0, 3));
            cr.s_m1 = 13'($urandom_range(0, 2));
            run_op(cr, int'($urandom_range(0, 3)), $sformatf("rand%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
